// File: rtl/pc_branch_ctrl_pkg.sv
// Shared definitions for the branch/PC controller of the 16-bit single-cycle core.
// Holds the opcode and condition-code encodings, the RUN/HALTED state type and a
// helper that maps an opcode to its flag write enables.
package pc_branch_ctrl_pkg;

  localparam int unsigned WORD_W = 16;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LHB    = 4'b1010;
  localparam logic [3:0] OP_LLB    = 4'b1011;
  localparam logic [3:0] OP_B      = 4'b1100;
  localparam logic [3:0] OP_BR     = 4'b1101;
  localparam logic [3:0] OP_PCS    = 4'b1110;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  localparam logic [2:0] CC_NE  = 3'b000;
  localparam logic [2:0] CC_EQ  = 3'b001;
  localparam logic [2:0] CC_GT  = 3'b010;
  localparam logic [2:0] CC_LT  = 3'b011;
  localparam logic [2:0] CC_GE  = 3'b100;
  localparam logic [2:0] CC_LE  = 3'b101;
  localparam logic [2:0] CC_OV  = 3'b110;
  localparam logic [2:0] CC_UNC = 3'b111;

  typedef enum logic {RUN, HALTED} state_e;

  typedef struct packed {
    logic z;
    logic nv;  // N and V are always written together
  } flag_we_t;

  function automatic flag_we_t flag_we(input logic [3:0] op);
    flag_we_t we;
    we = '{z: 1'b0, nv: 1'b0};
    case (op)
      OP_ADD, OP_SUB:                 we = '{z: 1'b1, nv: 1'b1};
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: we = '{z: 1'b1, nv: 1'b0};
      default:                        we = '{z: 1'b0, nv: 1'b0};
    endcase
    return we;
  endfunction

endpackage

// File: rtl/pc_branch_ctrl_if.sv
// Bundle between the decode/ALU side of the core and the PC/branch controller.
// master: drives instruction fields and ALU flags, receives pc/flags/halt status.
// slave:  the controller itself.
interface pc_branch_ctrl_if;
  import pc_branch_ctrl_pkg::*;

  logic              stall;
  logic [3:0]        opcode;
  logic [2:0]        ccc;
  logic [8:0]        imm9;
  logic [WORD_W-1:0] br_target;
  logic              alu_z;
  logic              alu_n;
  logic              alu_v;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc_plus2;
  logic              branch_taken;
  logic              flag_z;
  logic              flag_n;
  logic              flag_v;
  logic              halted;

  modport master (
    output stall, opcode, ccc, imm9, br_target, alu_z, alu_n, alu_v,
    input  pc, pc_plus2, branch_taken, flag_z, flag_n, flag_v, halted
  );

  modport slave (
    input  stall, opcode, ccc, imm9, br_target, alu_z, alu_n, alu_v,
    output pc, pc_plus2, branch_taken, flag_z, flag_n, flag_v, halted
  );
endinterface

// File: rtl/pc_branch_ctrl_branch_cond.sv
// Purely combinational branch condition evaluator.
// Ports: ccc_i condition code, z_i/n_i/v_i flag values, cond_o condition true.
module branch_cond
  import pc_branch_ctrl_pkg::*;
(
  input  logic [2:0] ccc_i,
  input  logic       z_i,
  input  logic       n_i,
  input  logic       v_i,
  output logic       cond_o
);

  always_comb begin
    cond_o = 1'b0;
    unique case (ccc_i)
      CC_NE:  cond_o = ~z_i;
      CC_EQ:  cond_o = z_i;
      CC_GT:  cond_o = ~z_i & ~n_i;
      CC_LT:  cond_o = n_i;
      CC_GE:  cond_o = z_i | ~n_i;
      CC_LE:  cond_o = z_i | n_i;
      CC_OV:  cond_o = v_i;
      CC_UNC: cond_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_branch_ctrl.sv
// PC register, architectural Z/N/V flags, B/BR resolution and RUN/HALTED control.
// Ports: clk, rst_n (async active-low), bus (slave side of pc_branch_ctrl_if):
//   inputs  stall, opcode, ccc, imm9, br_target, alu_z/n/v
//   outputs pc, pc_plus2 (comb), branch_taken (comb), flag_z/n/v, halted
module pc_branch_ctrl
  import pc_branch_ctrl_pkg::*;
#(
  parameter int unsigned     PC_W     = WORD_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic             clk,
  input logic             rst_n,
  pc_branch_ctrl_if.slave bus
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_plus2, imm_off, b_target;
  logic            z_q, z_d, n_q, n_d, v_q, v_d;
  logic            halted_q, halted_d;
  state_e          state_q, state_d;
  logic            cond, run, upd, is_b, is_br, taken;
  flag_we_t        we;

  branch_cond u_branch_cond (
    .ccc_i  (bus.ccc),
    .z_i    (z_q),
    .n_i    (n_q),
    .v_i    (v_q),
    .cond_o (cond)
  );

  assign run      = (state_q == RUN);
  assign upd      = run & ~bus.stall;
  assign is_b     = (bus.opcode == OP_B);
  assign is_br    = (bus.opcode == OP_BR);
  assign pc_plus2 = pc_q + PC_W'(2);
  // imm9 counts halfwords: sign-extend and shift left by one.
  assign imm_off  = {{(PC_W - 10){bus.imm9[8]}}, bus.imm9, 1'b0};
  assign b_target = pc_plus2 + imm_off;
  // Not gated by stall so a stalled branch still reports its resolution.
  assign taken    = (is_b | is_br) & cond & run;
  assign we       = flag_we(bus.opcode);

  always_comb begin
    pc_d     = pc_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
    state_d  = state_q;
    halted_d = halted_q;
    if (upd) begin
      if (bus.opcode == OP_HLT) begin
        state_d  = HALTED;
        halted_d = 1'b1;
      end else if (taken && is_b) begin
        pc_d = b_target;
      end else if (taken && is_br) begin
        pc_d = bus.br_target;
      end else begin
        pc_d = pc_plus2;
      end
      if (we.z) begin
        z_d = bus.alu_z;
      end
      if (we.nv) begin
        n_d = bus.alu_n;
        v_d = bus.alu_v;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      z_q      <= z_d;
      n_q      <= n_d;
      v_q      <= v_d;
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus2     = pc_plus2;
  assign bus.branch_taken = taken;
  assign bus.flag_z       = z_q;
  assign bus.flag_n       = n_q;
  assign bus.flag_v       = v_q;
  assign bus.halted       = halted_q;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Self-checking bench for pc_branch_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the architectural state.
module tb_pc_branch_ctrl;
  import pc_branch_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  pc_branch_ctrl_if bus ();

  pc_branch_ctrl #(
    .PC_W     (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  logic [15:0] m_pc;
  bit          m_z, m_n, m_v, m_halt;

  function automatic bit exp_cond(input logic [2:0] c, input bit z, input bit n, input bit v);
    case (c)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !z && !n;
      3'd3:    return n;
      3'd4:    return z || !n;
      3'd5:    return z || n;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit exp_taken();
    return !m_halt && (bus.opcode == 4'd12 || bus.opcode == 4'd13) &&
           exp_cond(bus.ccc, m_z, m_n, m_v);
  endfunction

  function automatic logic [15:0] exp_next_pc();
    int off;
    int nxt;
    off = int'(bus.imm9);
    if (off >= 256) off = off - 512;
    nxt = int'(m_pc) + 2;
    if (exp_taken() && bus.opcode == 4'd12) nxt = nxt + 2 * off;
    else if (exp_taken()) nxt = int'(bus.br_target);
    return 16'(nxt & 32'hFFFF);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc   <= 16'h0000;
      m_z    <= 1'b0;
      m_n    <= 1'b0;
      m_v    <= 1'b0;
      m_halt <= 1'b0;
    end else if (!m_halt && !bus.stall) begin
      if (bus.opcode == 4'd15) m_halt <= 1'b1;
      else m_pc <= exp_next_pc();
      if (bus.opcode <= 4'd1) begin
        m_z <= bus.alu_z;
        m_n <= bus.alu_n;
        m_v <= bus.alu_v;
      end else if (bus.opcode == 4'd2 || (bus.opcode >= 4'd4 && bus.opcode <= 4'd6)) begin
        m_z <= bus.alu_z;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("m_pc", 32'(bus.pc), 32'(m_pc));
      check("m_pc_plus2", 32'(bus.pc_plus2), 32'(16'(m_pc + 16'd2)));
      check("m_taken", 32'(bus.branch_taken), 32'(exp_taken()));
      check("m_flags", 32'({bus.flag_z, bus.flag_n, bus.flag_v}), 32'({m_z, m_n, m_v}));
      check("m_halted", 32'(bus.halted), 32'(m_halt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic [3:0] op, input logic [2:0] cc, input logic [8:0] imm,
                        input logic [15:0] brt, input logic z, input logic n, input logic v,
                        input logic st);
    bus.opcode    = op;
    bus.ccc       = cc;
    bus.imm9      = imm;
    bus.br_target = brt;
    bus.alu_z     = z;
    bus.alu_n     = n;
    bus.alu_v     = v;
    bus.stall     = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string name, input logic [2:0] exp_znv);
    check(name, 32'({bus.flag_z, bus.flag_n, bus.flag_v}), 32'(exp_znv));
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(OP_LW, 3'd0, 9'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_pc", 32'(bus.pc), 32'h0000);
    check_flags("rst_flags", 3'b000);
    check("rst_halted", 32'(bus.halted), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("seq_pc", 32'(bus.pc), 32'(2 * i));
    end

    // Flag write enables
    set_in(OP_ADD, 3'd0, 9'd0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check_flags("add_flags", 3'b011);
    set_in(OP_XOR, 3'd0, 9'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_flags("xor_flags", 3'b111);
    set_in(OP_ADD, 3'd0, 9'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(OP_LW, 3'd0, 9'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("pre_b_pc", 32'(bus.pc), 32'h0010);

    // B GT taken backwards, then B LT not taken
    set_in(OP_B, CC_GT, 9'h1FE, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("b_gt_taken", 32'(bus.branch_taken), 32'd1);
    tick();
    check("b_gt_pc", 32'(bus.pc), 32'h000E);
    set_in(OP_LW, 3'd0, 9'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(OP_B, CC_LT, 9'h1FE, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("b_lt_taken", 32'(bus.branch_taken), 32'd0);
    tick();
    check("b_lt_pc", 32'(bus.pc), 32'h0012);

    // BR unconditional
    set_in(OP_BR, CC_UNC, 9'd0, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(OP_BR, CC_UNC, 9'd0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("br_pc_plus2", 32'(bus.pc_plus2), 32'h0022);
    tick();
    check("br_pc", 32'(bus.pc), 32'h1234);

    // Wrap at FFFE
    set_in(OP_BR, CC_UNC, 9'd0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(OP_LW, 3'd0, 9'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("wrap_pc_plus2", 32'(bus.pc_plus2), 32'h0000);
    tick();
    check("wrap_pc", 32'(bus.pc), 32'h0000);

    // Stall holds pc and flags
    set_in(OP_ADD, 3'd0, 9'd0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    check("stall_pc", 32'(bus.pc), 32'h0000);
    check_flags("stall_flags", 3'b000);

    // HLT with a stalled first cycle
    set_in(OP_LW, 3'd0, 9'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    set_in(OP_HLT, 3'd0, 9'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("hlt_stall_pc", 32'(bus.pc), 32'h0008);
    check("hlt_stall_halted", 32'(bus.halted), 32'd0);
    bus.stall = 1'b0;
    tick();
    check("hlt_halted", 32'(bus.halted), 32'd1);
    check("hlt_pc", 32'(bus.pc), 32'h0008);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) set_in(OP_B, CC_UNC, 9'h001, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      else set_in(OP_ADD, 3'd0, 9'd0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      check("halt_taken", 32'(bus.branch_taken), 32'd0);
      tick();
      check("halt_pc", 32'(bus.pc), 32'h0008);
      check_flags("halt_flags", 3'b000);
    end

    // Async reset mid-cycle while halted
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_pc", 32'(bus.pc), 32'h0000);
    check("mid_rst_halted", 32'(bus.halted), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic, checked by the per-cycle compare process
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 99) < 2) ? OP_HLT : 4'($urandom_range(0, 14));
      set_in(op, 3'($urandom), 9'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 99) < 3) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick();
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_branch_ctrl.md
Name: pc_branch_ctrl

Overview:
- Consumer end of the ALU flag interface for the 16-bit single-cycle core.
- Latches Z/N/V from the ALU into an architectural flag register, using per-opcode write enables.
- Evaluates B/BR conditions against the registered flags and owns the PC register.
- Runs the RUN/HALTED state machine for HLT; feeds instruction fetch and the PCS writeback path.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_W, 16, PC and address width; fixed at 16 for this ISA.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  freeze: no PC, flag or state update this cycle.
- opcode  input  4  current instruction opcode [15:12].
- ccc  input  3  branch condition code [11:9].
- imm9  input  9  signed B offset in halfwords [8:0].
- br_target  input  16  rs register value for BR.
- alu_z  input  1  ALU zero flag, current instruction.
- alu_n  input  1  ALU negative flag, current instruction.
- alu_v  input  1  ALU overflow flag, current instruction.
- pc  output  16  registered PC to instruction memory.
- pc_plus2  output  16  pc+2, combinational; the PCS writeback value.
- branch_taken  output  1  combinational; current B/BR resolves taken.
- flag_z  output  1  registered Z.
- flag_n  output  1  registered N.
- flag_v  output  1  registered V.
- halted  output  1  registered; high once HLT has retired.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, flags=000, state=RUN, halted=0.
  - Takes effect immediately mid-operation.
- Flag write enables, gated by !stall and state==RUN:
  - ADD(0000)/SUB(0001): write Z, N, V.
  - XOR(0010)/SLL(0100)/SRA(0101)/ROR(0110): write Z only; N and V hold.
  - All other opcodes, including RED and PADDSB: no flag change.
- Flags update on the rising edge after the writing instruction. A branch in the same cycle sees the previously registered flags.
- Condition (cond) from the registered flags:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GE: Z | !N
  - 101 LE: Z | N
  - 110 OV: V
  - 111 always taken
- branch_taken = (opcode==1100 or 1101) & cond & state==RUN. It is not gated by stall.
- Next PC:
  - B taken: pc_plus2 + sign_ext(imm9)<<1, computed mod 2^16 (wraps, no fault).
  - BR taken: br_target.
  - Otherwise: pc_plus2.
  - pc_plus2 wraps FFFE to 0000.
- PC update: on each edge when !stall and state==RUN. Latency: 1 cycle from instruction to new pc.
- HLT (1111) in RUN and !stall:
  - pc holds (does not advance); state goes to HALTED and halted=1 on that edge.
- HALTED state:
  - pc, flags and state frozen; all inputs ignored until reset.
- stall=1: everything holds, including a pending HLT, which retires when stall drops.
- Simultaneous stall and reset: reset wins.
- A br_target LSB of 1 is passed through unmodified.

Decomposition:
- Shared package holds:
  - opcode constants (OP_ADD…OP_HLT);
  - ccc constants (CC_NE…CC_UNC);
  - state typedef {RUN, HALTED}.
- One sub-module, branch_cond: purely combinational (ccc, Z, N, V) -> cond. It is reused later by the pipelined branch-resolve stage.
- The PC adders stay inline.

Test Plan:
- Reset then 3 non-branch cycles -> pc 0000, 0002, 0004, 0006; flags 000; halted 0.
- ADD with alu_{z,n,v}=0,1,1, then XOR with alu_z=1, n=0, v=0 -> flags after ADD N=1 V=1 Z=0; after XOR Z=1, N=1, V=1 retained.
- Flags Z=0 N=0, pc=0010, B ccc=010 imm9=1FE (-2) -> branch_taken=1, next pc=000E. Same with ccc=011 -> not taken, pc=0012.
- BR ccc=111 br_target=1234 at pc=0020 -> pc=1234; pc_plus2=0022 while at 0020.
- pc=FFFE non-branch -> wraps to 0000. stall=1 for 2 cycles with ADD -> pc and flags unchanged.
- HLT at pc=0008 with stall=1 one cycle, then stall=0 -> halted=1 after release, pc stays 0008 for 5+ cycles. Assert rst_n=0 mid-halt -> pc=0000, halted=0 immediately.
